// File: rtl/imm_ext_pkg.sv
// Shared types and instruction field positions for the immediate-extension pipe.
// Format 4 (IW) is built only when IMM_EXT_IW_EN is defined.
package imm_ext_pkg;

    typedef enum logic [2:0] {
        ALU_IMM = 3'd0,
        DT      = 3'd1,
        B       = 3'd2,
        CB      = 3'd3,
        IW      = 3'd4
    } fmt_e;

    localparam int ALU_IMM_MSB = 21;
    localparam int ALU_IMM_LSB = 10;
    localparam int DT_MSB      = 20;
    localparam int DT_LSB      = 12;
    localparam int B_MSB       = 25;
    localparam int CB_MSB      = 23;
    localparam int CB_LSB      = 5;
    localparam int IW_MSB      = 20;
    localparam int IW_LSB      = 5;
    localparam int IW_HW_MSB   = 22;
    localparam int IW_HW_LSB   = 21;

    // Sign-extend v to 64 bits, treating bit msb as the sign bit.
    function automatic logic [63:0] sext64(input logic [63:0] v, input int msb);
        logic [63:0] keep;
        logic [5:0]  m;
        m    = 6'(msb);
        keep = {64{1'b1}} >> (63 - msb);
        return v[m] ? (v | ~keep) : (v & keep);
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extraction/extension for one instruction word.
// The IW format and its shifter exist only when IMM_EXT_IW_EN is defined.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
    output logic [DATA_W-1:0] imm,
    output logic              err
);

    logic [63:0] imm_full;
    logic        unused_instr;

    assign unused_instr = ^instr[31:26];

    always_comb begin
        imm_full = '0;
        err      = 1'b0;
        case (fmt)
            ALU_IMM: imm_full = 64'(instr[ALU_IMM_MSB:ALU_IMM_LSB]);
            DT:      imm_full = sext64(64'(instr[DT_MSB:DT_LSB]), DT_MSB - DT_LSB);
            B:       imm_full = sext64(64'({instr[B_MSB:0], 2'b00}), B_MSB + 2);
            CB:      imm_full = sext64(64'({instr[CB_MSB:CB_LSB], 2'b00}),
                                       CB_MSB - CB_LSB + 2);
`ifdef IMM_EXT_IW_EN
            IW: begin
                // A 32-bit result cannot hold the upper two halfword positions.
                if (DATA_W == 32 && instr[IW_HW_MSB]) begin
                    err = 1'b1;
                end else begin
                    imm_full = 64'(instr[IW_MSB:IW_LSB])
                               << {instr[IW_HW_MSB:IW_HW_LSB], 4'b0000};
                end
            end
`endif
            default: err = 1'b1;
        endcase
    end

    assign imm = imm_full[DATA_W-1:0];

endmodule

// File: rtl/imm_ext_pipe.sv
// Two-stage valid/ready pipe: S1 holds the raw request, S2 the extended immediate.
// DATA_W must be 32 or 64; IMM_EXT_IW_EN enables the IW format.
module imm_ext_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic              err,
    output logic [TAG_W-1:0]  out_tag,
    output logic [7:0]        err_cnt
);

    logic              s1_valid_q;
    logic [31:0]       s1_instr_q;
    logic [2:0]        s1_fmt_q;
    logic [TAG_W-1:0]  s1_tag_q;

    logic              s2_valid_q;
    logic [DATA_W-1:0] s2_imm_q;
    logic              s2_err_q;
    logic [TAG_W-1:0]  s2_tag_q;

    logic [7:0]        err_cnt_q;

    logic [DATA_W-1:0] core_imm;
    logic              core_err;
    logic              s1_en;
    logic              s2_en;
    logic              handoff;

    // Each stage may load when it is empty or its contents move on this cycle.
    assign s2_en    = !s2_valid_q || out_ready;
    assign s1_en    = !s1_valid_q || s2_en;
    assign in_ready = s1_en;
    assign handoff  = s2_valid_q && out_ready;

    imm_ext_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .instr (s1_instr_q),
        .fmt   (s1_fmt_q),
        .imm   (core_imm),
        .err   (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_instr_q <= '0;
            s1_fmt_q   <= '0;
            s1_tag_q   <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_instr_q <= instr;
                s1_fmt_q   <= fmt;
                s1_tag_q   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_imm_q   <= '0;
            s2_err_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else if (s2_en) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_imm_q <= core_imm;
                s2_err_q <= core_err;
                s2_tag_q <= s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (handoff && s2_err_q && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign out_valid = s2_valid_q;
    assign imm       = s2_imm_q;
    assign err       = s2_err_q;
    assign out_tag   = s2_tag_q;
    assign err_cnt   = err_cnt_q;

endmodule
